// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LLR constants, types and saturation helpers
// Contents: LLR_W / MAX_DV defaults, packed edge vector type,
//           sat_llr (symmetric saturation), clamp_llr (-2^(w-1) fix-up).
package ldpc_pkg;

   localparam int LLR_W  = 8;
   localparam int MAX_DV = 16;

   typedef logic signed [LLR_W-1:0]          llr_t;
   typedef logic [MAX_DV-1:0][LLR_W-1:0]     edge_vec_t;

   // Saturate to the symmetric range [-(2^(width-1)-1), +(2^(width-1)-1)].
   function automatic int sat_llr(input int value, input int width);
      int lim;
      lim = (1 << (width - 1)) - 1;
      if (value > lim)
         return lim;
      else if (value < -lim)
         return -lim;
      else
         return value;
   endfunction

   // The most negative code has no positive twin; pull it in by one so
   // negation and saturation stay symmetric.
   function automatic int clamp_llr(input int value, input int width);
      if (value == -(1 << (width - 1)))
         return value + 1;
      else
         return value;
   endfunction

endpackage

// File: rtl/vnu_sat.sv
// rtl/vnu_sat.sv - combinational symmetric saturation from IN_W to OUT_W bits
// Ports: wide (IN_W signed in), llr (OUT_W signed, saturated out).
module vnu_sat
   import ldpc_pkg::*;
#(
   parameter int IN_W  = 10,
   parameter int OUT_W = 8
) (
   input  logic signed [IN_W-1:0]  wide,
   output logic signed [OUT_W-1:0] llr
);

   assign llr = OUT_W'(sat_llr(int'(wide), OUT_W));

endmodule

// File: rtl/vnu_pipe.sv
// rtl/vnu_pipe.sv - two-stage pipelined min-sum variable-node update
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, first_iter,
//        intrinsic_info, msg_from_check (edge k at [k*W +: W]);
//        out_valid/out_ready, msg_to_check, hard_bit; vnu_over pulse.
module vnu_pipe
   import ldpc_pkg::*;
#(
   parameter int W  = LLR_W,
   parameter int DV = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                first_iter,
   input  logic signed [W-1:0] intrinsic_info,
   input  logic [DV*W-1:0]     msg_from_check,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DV*W-1:0]     msg_to_check,
   output logic                hard_bit,
   output logic                vnu_over
);

   // Wide enough for (DV+1) full-scale terms without overflow.
   localparam int SW = W + $clog2(DV + 1);

   logic                 s1_adv, s2_adv;
   logic                 s1_valid;
   logic                 s1_first;
   logic signed [SW-1:0] s1_total;
   logic signed [W-1:0]  s1_msg [DV];

   logic signed [W-1:0]  intr_c;
   logic signed [W-1:0]  msg_c [DV];
   logic signed [SW-1:0] sum_c;
   logic signed [SW-1:0] ext_c [DV];
   logic signed [W-1:0]  sat_c [DV];
   logic [DV*W-1:0]      msg_next;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // S1: clamp inputs and form the a-posteriori total.
   always_comb begin
      intr_c = W'(clamp_llr(int'(intrinsic_info), W));
      sum_c  = SW'(intr_c);
      for (int k = 0; k < DV; k++) begin
         msg_c[k] = W'(clamp_llr(int'($signed(msg_from_check[k*W +: W])), W));
         if (!first_iter)
            sum_c = sum_c + SW'(msg_c[k]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_first <= 1'b0;
         s1_total <= '0;
         for (int k = 0; k < DV; k++)
            s1_msg[k] <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_first <= first_iter;
            s1_total <= sum_c;
            for (int k = 0; k < DV; k++)
               s1_msg[k] <= msg_c[k];
         end
      end
   end

   // S2: extrinsic = total minus own edge; in first-iteration mode the
   // edge contributed nothing to the total, so nothing is removed.
   always_comb begin
      for (int k = 0; k < DV; k++)
         ext_c[k] = s1_first ? s1_total : (s1_total - SW'(s1_msg[k]));
   end

   for (genvar k = 0; k < DV; k++) begin : g_sat
      vnu_sat #(.IN_W(SW), .OUT_W(W)) u_sat (
         .wide (ext_c[k]),
         .llr  (sat_c[k])
      );
      assign msg_next[k*W +: W] = sat_c[k];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         msg_to_check <= '0;
         hard_bit     <= 1'b0;
         vnu_over     <= 1'b0;
      end else begin
         vnu_over <= out_valid && out_ready;
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               msg_to_check <= msg_next;
               hard_bit     <= s1_total[SW-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_vnu_pipe.sv
// tb/tb_vnu_pipe.sv - directed self-checking bench for vnu_pipe (W=8, DV=3)
module tb_vnu_pipe;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              first_iter;
   logic signed [7:0] intrinsic_info;
   logic [23:0]       msg_from_check;
   logic              out_valid;
   logic              out_ready;
   logic [23:0]       msg_to_check;
   logic              hard_bit;
   logic              vnu_over;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vnu_pipe #(.W(8), .DV(3)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .first_iter     (first_iter),
      .intrinsic_info (intrinsic_info),
      .msg_from_check (msg_from_check),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .msg_to_check   (msg_to_check),
      .hard_bit       (hard_bit),
      .vnu_over       (vnu_over)
   );

   task automatic set_in(input logic fi, input int intr, input int m0, input int m1, input int m2);
      in_valid       = 1'b1;
      first_iter     = fi;
      intrinsic_info = 8'(intr);
      msg_from_check = {8'(m2), 8'(m1), 8'(m0)};
   endtask

   // Called at a negedge with in_ready high; returns at the negedge where
   // out_valid is first seen, lat = number of negedges after the drive.
   task automatic push(input logic fi, input int intr, input int m0, input int m1, input int m2,
                       output int lat);
      set_in(fi, intr, m0, m1, m2);
      @(negedge clk);
      in_valid = 1'b0;
      lat = -1;
      for (int c = 1; c <= 8; c++) begin
         if (out_valid) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      first_iter = 1'b0; intrinsic_info = '0; msg_from_check = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, hard_bit, vnu_over} !== 3'b000 || msg_to_check !== 24'h0) begin
         failures++;
         $display("FAIL reset_state: got ov=%b hb=%b over=%b msg=%h, want 0 0 0 000000",
                  out_valid, hard_bit, vnu_over, msg_to_check);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_nominal;
      int lat;
      push(1'b0, 10, 5, -3, 7, lat);
      checks++;
      if (lat != 2) begin
         failures++;
         $display("FAIL nominal_latency: got %0d want 2", lat);
      end
      checks++;
      if (msg_to_check !== 24'h0c160e || hard_bit !== 1'b0) begin
         failures++;
         $display("FAIL nominal_data: got msg=%h hb=%b want 0c160e 0", msg_to_check, hard_bit);
      end
      @(negedge clk);
      checks++;
      if (vnu_over !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL nominal_over: got over=%b ov=%b want 1 0", vnu_over, out_valid);
      end
      @(negedge clk);
      checks++;
      if (vnu_over !== 1'b0) begin
         failures++;
         $display("FAIL nominal_over_clear: got %b want 0", vnu_over);
      end
   endtask

   task automatic test_saturation;
      int lat;
      push(1'b0, 100, 100, 100, 100, lat);
      checks++;
      if (lat != 2 || msg_to_check !== 24'h7f7f7f || hard_bit !== 1'b0) begin
         failures++;
         $display("FAIL sat_pos: got lat=%0d msg=%h hb=%b want 2 7f7f7f 0", lat, msg_to_check, hard_bit);
      end
      push(1'b0, -128, -100, -100, -100, lat);
      checks++;
      if (lat != 2 || msg_to_check !== 24'h818181 || hard_bit !== 1'b1) begin
         failures++;
         $display("FAIL sat_neg: got lat=%0d msg=%h hb=%b want 2 818181 1", lat, msg_to_check, hard_bit);
      end
      @(negedge clk);
   endtask

   task automatic test_first_iter;
      int lat;
      push(1'b1, -20, 50, 60, 70, lat);
      checks++;
      if (lat != 2 || msg_to_check !== 24'hececec || hard_bit !== 1'b1) begin
         failures++;
         $display("FAIL first_iter: got lat=%0d msg=%h hb=%b want 2 ececec 1", lat, msg_to_check, hard_bit);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_total;
      int lat;
      push(1'b0, 0, 3, -3, 0, lat);
      checks++;
      if (lat != 2 || msg_to_check !== 24'h0003fd || hard_bit !== 1'b0) begin
         failures++;
         $display("FAIL zero_total: got lat=%0d msg=%h hb=%b want 2 0003fd 0", lat, msg_to_check, hard_bit);
      end
      @(negedge clk);
   endtask

   // A: 1 | 1,2,3 -> 6,5,4 ; B: -5 | 0,0,0 -> -5 x3 ; C: first_iter 40 -> 40 x3
   task automatic test_back_to_back;
      @(negedge clk);
      out_ready = 1'b0;
      set_in(1'b0, 1, 1, 2, 3);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_accept_b: got rdy=%b ov=%b want 1 0", in_ready, out_valid);
      end
      set_in(1'b0, -5, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || msg_to_check !== 24'h040506 || hard_bit !== 1'b0) begin
         failures++;
         $display("FAIL bp_full: got rdy=%b ov=%b msg=%h hb=%b want 0 1 040506 0",
                  in_ready, out_valid, msg_to_check, hard_bit);
      end
      set_in(1'b1, 40, 9, 9, 9);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || msg_to_check !== 24'h040506 || vnu_over !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold%0d: got rdy=%b ov=%b msg=%h over=%b want 0 1 040506 0",
                     i, in_ready, out_valid, msg_to_check, vnu_over);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release_rdy: got %b want 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || msg_to_check !== 24'hfbfbfb || hard_bit !== 1'b1 || vnu_over !== 1'b1) begin
         failures++;
         $display("FAIL bp_out_b: got ov=%b msg=%h hb=%b over=%b want 1 fbfbfb 1 1",
                  out_valid, msg_to_check, hard_bit, vnu_over);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || msg_to_check !== 24'h282828 || hard_bit !== 1'b0 || vnu_over !== 1'b1) begin
         failures++;
         $display("FAIL bp_out_c: got ov=%b msg=%h hb=%b over=%b want 1 282828 0 1",
                  out_valid, msg_to_check, hard_bit, vnu_over);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || vnu_over !== 1'b1) begin
         failures++;
         $display("FAIL bp_drain: got ov=%b over=%b want 0 1", out_valid, vnu_over);
      end
      @(negedge clk);
      checks++;
      if (vnu_over !== 1'b0) begin
         failures++;
         $display("FAIL bp_over_end: got %b want 0", vnu_over);
      end
   endtask

   task automatic test_reset_mid;
      int seen;
      out_ready = 1'b0;
      set_in(1'b0, 10, 5, -3, 7);
      @(negedge clk);
      set_in(1'b0, 100, 100, 100, 100);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || msg_to_check !== 24'h0c160e) begin
         failures++;
         $display("FAIL rst_mid_pre: got ov=%b msg=%h want 1 0c160e", out_valid, msg_to_check);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || msg_to_check !== 24'h0 || hard_bit !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_async: got ov=%b msg=%h hb=%b want 0 000000 0",
                  out_valid, msg_to_check, hard_bit);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_rdy: got %b want 1", in_ready);
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL rst_mid_flush: got %0d outputs want 0", seen);
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_saturation;
      test_first_iter;
      test_zero_total;
      test_back_to_back;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
